// File: rtl/alu_seq.sv
// Handshaked single-entry execute unit: ADD/SUB/NAND/XOR in one step, shifts and
// rotates one bit per cycle, registered Z/V/N/err flags held until consumed.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_z,
    output logic             out_v,
    output logic             out_n,
    output logic             out_err
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;

    logic [1:0]       state_q, state_d;
    logic [1:0]       sh_op_q, sh_op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             err_q, err_d;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] arith_res;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] step;

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_z      = z_q;
    assign out_v      = v_q;
    assign out_n      = n_q;
    assign out_err    = err_q;

    // SUB reuses the adder as A + ~B + 1; overflow is judged against the effective B.
    assign is_sub    = (opcode == OP_SUB);
    assign b_eff     = is_sub ? ~in_b : in_b;
    assign sum       = in_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    assign ovf       = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign sat_val   = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign arith_res = (SAT && ovf) ? sat_val : sum;
    assign amt       = in_b[SHW-1:0];

    always_comb begin
        step = {work_q[0], work_q[WIDTH-1:1]};
        case (sh_op_q)
            2'b00:   step = {work_q[WIDTH-2:0], 1'b0};
            2'b01:   step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: step = {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        logic             fin;
        logic [WIDTH-1:0] r;
        logic             v;
        logic             e;
        state_d = state_q;
        sh_op_d = sh_op_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        err_d   = err_q;
        fin     = 1'b0;
        r       = '0;
        v       = 1'b0;
        e       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            fin = 1'b1;
                            r   = arith_res;
                            v   = ovf;
                            e   = ovf;
                        end
                        OP_NAND: begin
                            fin = 1'b1;
                            r   = ~(in_a & in_b);
                        end
                        OP_XOR: begin
                            fin = 1'b1;
                            r   = in_a ^ in_b;
                        end
                        OP_SLL, OP_SRA, OP_ROR: begin
                            if (amt == '0) begin
                                fin = 1'b1;
                                r   = in_a;
                            end else begin
                                work_d  = in_a;
                                cnt_d   = amt;
                                sh_op_d = opcode[1:0];
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
                            // Reserved (and any unknown) opcode.
                            fin = 1'b1;
                            e   = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    fin = 1'b1;
                    r   = step;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            res_d   = r;
            z_d     = (r == '0);
            n_d     = r[WIDTH-1];
            v_d     = v;
            err_d   = e;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_op_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_op_q <= sh_op_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: a wrapping and a saturating instance
// driven from the same inputs, checked against hand-computed results.
module tb_alu_seq;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] opcode;
    logic       out_ready;

    logic       in_ready0, out_valid0, z0, v0, n0, err0;
    logic [7:0] res0;
    logic       in_ready1, out_valid1, z1, v1, n1, err1;
    logic [7:0] res1;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid0),
        .out_ready(out_ready), .out_result(res0), .out_z(z0), .out_v(v0),
        .out_n(n0), .out_err(err0)
    );

    alu_seq #(.WIDTH(8), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid1),
        .out_ready(out_ready), .out_result(res1), .out_z(z1), .out_v(v1),
        .out_n(n1), .out_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; e0/e1 = {result, z, v, n, err} for wrap/sat instances.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input int lat,
                         input logic [11:0] e0, input logic [11:0] e1);
        int cyc;
        in_a = a;
        in_b = b;
        opcode = op;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a;
        in_b = ~b;
        opcode = 3'b010;
        cyc = 1;
        while (!out_valid0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_wrap"}, {res0, z0, v0, n0, err0}, e0);
        chk({tag, "_sat_valid"}, out_valid1, 1);
        chk({tag, "_sat"}, {res1, z1, v1, n1, err1}, e1);
        $display("op %s a=%02h b=%02h opcode=%0d -> wrap=%02h sat=%02h lat=%0d", tag, a, b, op, res0, res1, cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_consumed"}, out_valid0, 0);
        chk({tag, "_ready_again"}, in_ready0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        opcode = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid0, 0);
        chk("reset_outs", {res0, z0, v0, n0, err0}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready0, 1);

        do_op("add_ovf",   8'h7F, 8'h01, 3'b000, 1, {8'h80, 4'b0111}, {8'h7F, 4'b0101});
        do_op("sub_ovf",   8'h80, 8'h01, 3'b001, 1, {8'h7F, 4'b0101}, {8'h80, 4'b0111});
        do_op("sub_zero",  8'h05, 8'h05, 3'b001, 1, {8'h00, 4'b1000}, {8'h00, 4'b1000});
        do_op("add_plain", 8'h01, 8'h02, 3'b000, 1, {8'h03, 4'b0000}, {8'h03, 4'b0000});
        do_op("nand",      8'hF0, 8'hFF, 3'b010, 1, {8'h0F, 4'b0000}, {8'h0F, 4'b0000});
        do_op("xor",       8'hAA, 8'h0F, 3'b011, 1, {8'hA5, 4'b0010}, {8'hA5, 4'b0010});
        do_op("sra3",      8'h90, 8'h03, 3'b101, 4, {8'hF2, 4'b0010}, {8'hF2, 4'b0010});
        do_op("ror1",      8'h81, 8'h01, 3'b110, 2, {8'hC0, 4'b0010}, {8'hC0, 4'b0010});
        do_op("sll7",      8'h01, 8'h07, 3'b100, 8, {8'h80, 4'b0010}, {8'h80, 4'b0010});
        do_op("sll0",      8'h5A, 8'h00, 3'b100, 1, {8'h5A, 4'b0000}, {8'h5A, 4'b0000});
        do_op("reserved",  8'h33, 8'h44, 3'b111, 1, {8'h00, 4'b1001}, {8'h00, 4'b1001});

        // Backpressure: result held while a competing request waits.
        in_a = 8'h3C; in_b = 8'hC3; opcode = 3'b011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 8'h10; in_b = 8'h20; opcode = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid0, 1);
            chk("bp_hold", {res0, z0, v0, n0, err0}, {8'hFF, 4'b0010});
            chk("bp_in_ready", in_ready0, 0);
            @(posedge clk); #1;
        end
        $display("backpressure held result=%02h for 5 cycles", res0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid0, 0);
        chk("bp_release_ready", in_ready0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid0, 1);
        chk("bp_next_result", res0, 8'h30);
        $display("after release accepted add -> %02h", res0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of an SLL by 6.
        in_a = 8'h01; in_b = 8'h06; opcode = 3'b100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", out_valid0, 0);
        chk("midrst_outs", {res0, z0, v0, n0, err0}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready0, 1);
        repeat (8) begin
            @(posedge clk); #1;
            chk("midrst_no_output", out_valid0, 0);
        end
        $display("reset mid-shift discarded operation");
        do_op("post_rst_rsv", 8'hFF, 8'hFF, 3'b111, 1, {8'h00, 4'b1001}, {8'h00, 4'b1001});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
